dmem_mmio_responder: RTL and testbench

This block is the responder on the core's data-memory port. It takes the write enable, byte address and write data that the pipelined datapath drives, and returns read data combinationally in the same cycle. The address space holds a word RAM region and an MMIO region. The MMIO region contains a 64-bit cycle timer with a compare interrupt and a byte TX FIFO that drains over a valid/ready stream. It sits beside the core in the SoC top and replaces a bare data RAM.

---
 rtl/dmem_mmio_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core's load/store port.
// Decodes each access into a word RAM region, a small MMIO register block
// (64-bit cycle timer with compare interrupt, byte TX FIFO with a
// valid/ready drain) or unmapped space. Load data is combinational from the
// address and the current state; all state changes on the rising clock edge.
module dmem_mmio_responder #(
  parameter int                WIDTH      = 32,
  parameter int                ADDR_W     = 32,
  parameter int                MEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 32'h8000_0000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_d_add,
  input  logic [WIDTH-1:0]  i_w_data,
  output logic [WIDTH-1:0]  o_r_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_timer_irq,
  output logic              o_bus_err
);

  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Word index of each MMIO register relative to MMIO_BASE.
  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_TX_DATA     = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;

  // Six 32-bit registers occupy 24 bytes above the base.
  localparam logic [ADDR_W-1:0] MMIO_SPAN = ADDR_W'(24);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] mmio_off;
  logic              ram_hit;
  logic              mmio_hit;
  logic              unmapped;
  logic              mmio_we;
  logic [2:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       w_word;

  // Byte lanes are ignored: every access is a full word.
  assign word_addr = i_d_add & ~ADDR_W'(3);
  // Wrap-around subtraction makes anything below the base look huge, so a
  // single unsigned compare bounds the window on both sides.
  assign mmio_off  = word_addr - MMIO_BASE;
  assign ram_hit   = (word_addr[ADDR_W-1:RAM_AW+2] == '0);
  assign mmio_hit  = !ram_hit && (mmio_off < MMIO_SPAN);
  assign unmapped  = !ram_hit && !mmio_hit;
  assign mmio_we   = i_we && mmio_hit;
  assign reg_sel   = mmio_off[4:2];
  assign ram_idx   = word_addr[RAM_AW+1:2];
  assign w_word    = i_w_data[31:0];

  // ---------------------------------------------------------------------
  // Word RAM
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] ram [MEM_DEPTH];
  logic [WIDTH-1:0] ram_rdata;

  // Store port; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we && ram_hit) begin
      ram[ram_idx] <= i_w_data;
    end
  end

  // Asynchronous read gives old data during a same-address write.
  assign ram_rdata = ram[ram_idx];

  // ---------------------------------------------------------------------
  // Cycle timer and compare interrupt
  // ---------------------------------------------------------------------
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_nx;
  logic [63:0] mtimecmp_nx;

  // Next timer values: free-running increment unless software loads a half,
  // in which case the other half holds and that cycle does not count.
  always_comb begin
    mtime_nx    = mtime + 64'd1;
    mtimecmp_nx = mtimecmp;
    if (mmio_we) begin
      case (reg_sel)
        REG_MTIME_LO:    mtime_nx    = {mtime[63:32], w_word};
        REG_MTIME_HI:    mtime_nx    = {w_word, mtime[31:0]};
        REG_MTIMECMP_LO: mtimecmp_nx = {mtimecmp[63:32], w_word};
        REG_MTIMECMP_HI: mtimecmp_nx = {w_word, mtimecmp[31:0]};
        default:         ;
      endcase
    end
  end

  // Timer registers; the irq compares the values being loaded this edge so
  // it lines up with the cycle in which mtime first reaches mtimecmp.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      o_timer_irq <= 1'b0;
    end else begin
      mtime       <= mtime_nx;
      mtimecmp    <= mtimecmp_nx;
      o_timer_irq <= (mtime_nx >= mtimecmp_nx);
    end
  end

  // ---------------------------------------------------------------------
  // TX byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             ovf_clr;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = mmio_we && (reg_sel == REG_TX_DATA);
  assign pop        = !fifo_empty && i_tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing leaves.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = mmio_we && (reg_sel == REG_STATUS) && w_word[2];

  // Byte storage; when full, wr_ptr equals rd_ptr, so a push-with-pop
  // overwrites the head slot only as the head byte leaves.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= w_word[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Head byte is masked while empty so stale storage never shows and the
  // stream drops immediately when reset empties the FIFO.
  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------
  // Bus error
  // ---------------------------------------------------------------------
  // One-cycle error pulse after a store to an unmapped address.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_bus_err <= 1'b0;
    end else begin
      o_bus_err <= unmapped && i_we;
    end
  end

  // ---------------------------------------------------------------------
  // Load data mux
  // ---------------------------------------------------------------------
  logic [3:0]       cnt4;
  logic [7:0]       status_word;
  logic [WIDTH-1:0] r_data;

  assign cnt4        = 4'(count);
  assign status_word = {cnt4, o_timer_irq, overflow, fifo_empty, fifo_full};

  // Select load data by region; TX_DATA and unmapped space read as zero.
  always_comb begin
    r_data = '0;
    if (ram_hit) begin
      r_data = ram_rdata;
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_MTIME_LO:    r_data = WIDTH'(mtime[31:0]);
        REG_MTIME_HI:    r_data = WIDTH'(mtime[63:32]);
        REG_MTIMECMP_LO: r_data = WIDTH'(mtimecmp[31:0]);
        REG_MTIMECMP_HI: r_data = WIDTH'(mtimecmp[63:32]);
        REG_STATUS:      r_data = WIDTH'(status_word);
        default:         r_data = '0;
      endcase
    end
  end

  assign o_r_data = r_data;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: a register-map level model (associative
// RAM, 64-bit timer, byte queue) is checked against the DUT on every
// falling edge, and directed sequences pin the model with literal values.
module tb_dmem_mmio_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          FDEPTH = 4;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b1;
  logic        we    = 1'b0;
  logic [31:0] addr  = BASE;
  logic [31:0] wdata = '0;
  logic        ready = 1'b0;
  logic [31:0] o_r_data;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        o_timer_irq;
  logic        o_bus_err;

  dmem_mmio_responder #(
    .WIDTH(32), .ADDR_W(32), .MEM_DEPTH(1024), .MMIO_BASE(BASE), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_we(we), .i_d_add(addr), .i_w_data(wdata),
    .o_r_data(o_r_data), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .i_tx_ready(ready), .o_timer_irq(o_timer_irq), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] m_ram [int];
  bit [63:0] m_mtime = '0;
  bit [63:0] m_cmp   = '1;
  bit [7:0]  m_q [$];
  bit        m_ovf   = 1'b0;
  bit        m_irq   = 1'b0;
  bit        m_berr  = 1'b0;

  // -2 = RAM, -1 = unmapped, 0..5 = MMIO register number
  function automatic int region(input logic [31:0] a);
    bit [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 32'd4096) return -2;
    if (w >= BASE && w < BASE + 32'd24) return int'((w - BASE) / 32'd4);
    return -1;
  endfunction

  function automatic void exp_read(input logic [31:0] a, output bit known, output bit [31:0] v);
    int r;
    int idx;
    r = region(a);
    known = 1'b1;
    v = '0;
    if (r == -2) begin
      idx = int'((a & 32'h0000_0FFC) / 32'd4);
      if (m_ram.exists(idx)) v = m_ram[idx];
      else known = 1'b0;
    end else begin
      case (r)
        0: v = m_mtime[31:0];
        1: v = m_mtime[63:32];
        2: v = m_cmp[31:0];
        3: v = m_cmp[63:32];
        5: v = 32'(m_q.size()) * 16 + (m_irq ? 8 : 0) + (m_ovf ? 4 : 0)
               + (m_q.size() == 0 ? 2 : 0) + (m_q.size() == FDEPTH ? 1 : 0);
        default: v = '0;
      endcase
    end
  endfunction

  initial begin : model
    int r;
    int sz;
    bit pop;
    bit [63:0] nt;
    bit [63:0] nc;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_mtime = '0; m_cmp = '1; m_q.delete(); m_ovf = 0; m_irq = 0; m_berr = 0;
      end else begin
        r = region(addr);
        if (we && r == -2) m_ram[int'((addr & 32'h0000_0FFC) / 32'd4)] = wdata;
        nt = m_mtime + 64'd1;
        nc = m_cmp;
        if (we) begin
          case (r)
            0: nt = {m_mtime[63:32], wdata};
            1: nt = {wdata, m_mtime[31:0]};
            2: nc = {m_cmp[63:32], wdata};
            3: nc = {wdata, m_cmp[31:0]};
            default: ;
          endcase
        end
        m_mtime = nt;
        m_cmp   = nc;
        m_irq   = (nt >= nc);
        sz  = m_q.size();
        pop = (sz > 0) && ready;
        if (pop) void'(m_q.pop_front());
        if (we && r == 4) begin
          if (sz < FDEPTH || pop) m_q.push_back(wdata[7:0]);
          else m_ovf = 1'b1;
        end
        if (we && r == 5 && wdata[2]) m_ovf = 1'b0;
        m_berr = we && (r == -1);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin : compare
    bit known;
    bit [31:0] v;
    forever begin
      @(negedge clk);
      exp_read(addr, known, v);
      if (known) chk("model_r_data", o_r_data, v);
      chk("model_tx_valid", o_tx_valid, m_q.size() != 0);
      chk("model_tx_data", o_tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
      chk("model_timer_irq", o_timer_irq, m_irq);
      chk("model_bus_err", o_bus_err, m_berr);
    end
  end

  // One bus cycle: inputs change just after the rising edge.
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    @(posedge clk);
    #1;
    we = w; addr = a; wdata = d; ready = rdy;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    #1 rstn = 1'b0;
    addr = BASE + 32'd8;
    #2;
    chk("rst_mtimecmp_lo", o_r_data, 32'hFFFF_FFFF);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_timer_irq", o_timer_irq, 0);
    chk("rst_bus_err", o_bus_err, 0);
    addr = BASE;
    #1 chk("rst_mtime_lo", o_r_data, 0);
    #8 rstn = 1'b1;

    // RAM
    bus(1, 32'h10, 32'hDEAD_BEEF, 0);
    bus(0, 32'h10, 0, 0); #3 chk("ram_rd_10", o_r_data, 32'hDEAD_BEEF);
    bus(0, 32'h13, 0, 0); #3 chk("ram_rd_13", o_r_data, 32'hDEAD_BEEF);
    bus(1, 32'h14, 32'h1111_1111, 0);
    bus(1, 32'h14, 32'h2222_2222, 0); #3 chk("ram_rdw_old", o_r_data, 32'h1111_1111);
    bus(0, 32'h14, 0, 0); #3 chk("ram_rdw_new", o_r_data, 32'h2222_2222);

    // Timer and compare interrupt
    bus(1, BASE + 32'hC, 0, 0);
    bus(1, BASE + 32'h8, 32'd20, 0);
    bus(1, BASE, 32'd10, 0);
    for (int k = 0; k < 14; k++) begin
      bus(0, BASE, 0, 0);
      #3;
      chk("mtime_count", o_r_data, 32'd10 + 32'(k));
      chk("irq_timing", o_timer_irq, (k >= 10) ? 1 : 0);
    end
    bus(1, BASE + 32'h8, 32'd1000, 0); #3 chk("irq_still_set", o_timer_irq, 1);
    bus(0, BASE, 0, 0); #3 chk("irq_cleared", o_timer_irq, 0);

    // Timer carry into the high half
    bus(1, BASE + 32'h4, 0, 0);
    bus(1, BASE, 32'hFFFF_FFFF, 0);
    bus(0, BASE, 0, 0); #3 chk("wrap_lo_loaded", o_r_data, 32'hFFFF_FFFF);
    bus(0, BASE + 32'h4, 0, 0); #3 chk("wrap_hi", o_r_data, 1);
    bus(0, BASE, 0, 0); #3 chk("wrap_lo", o_r_data, 1);
    bus(1, BASE + 32'hC, 32'hFFFF_FFFF, 0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 4; i++) bus(1, BASE + 32'h10, 32'h41 + 32'(i), 0);
    bus(0, BASE + 32'h14, 0, 0); #3;
    chk("status_full", o_r_data, 32'h41);
    chk("head_41", o_tx_data, 8'h41);
    bus(1, BASE + 32'h10, 32'h45, 0);
    bus(0, BASE + 32'h14, 0, 0); #3 chk("status_overflow", o_r_data, 32'h45);
    for (int i = 0; i < 4; i++) begin
      bus(0, BASE + 32'h14, 0, 1); #3 chk("drain_order", o_tx_data, 8'h41 + 8'(i));
    end
    bus(0, BASE + 32'h14, 0, 0); #3;
    chk("drained_valid", o_tx_valid, 0);
    chk("status_empty", o_r_data, 32'h06);
    bus(0, BASE + 32'h10, 0, 0); #3 chk("tx_data_reads_zero", o_r_data, 0);
    bus(1, BASE + 32'h14, 32'h4, 0);
    bus(0, BASE + 32'h14, 0, 0); #3 chk("overflow_cleared", o_r_data, 32'h02);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) bus(1, BASE + 32'h10, 32'h51 + 32'(i), 0);
    bus(1, BASE + 32'h10, 32'h55, 1); #3 chk("simul_head", o_tx_data, 8'h51);
    bus(0, BASE + 32'h14, 0, 0); #3;
    chk("simul_status", o_r_data, 32'h41);
    chk("simul_next_head", o_tx_data, 8'h52);
    for (int i = 0; i < 4; i++) begin
      bus(0, BASE + 32'h14, 0, 1); #3 chk("simul_drain", o_tx_data, 8'h52 + 8'(i));
    end
    bus(0, BASE + 32'h14, 0, 0); #3 chk("simul_empty", o_r_data, 32'h02);

    // Push with pop at count 1
    bus(1, BASE + 32'h10, 32'h71, 0);
    bus(1, BASE + 32'h10, 32'h72, 1);
    bus(0, BASE + 32'h14, 0, 0); #3;
    chk("pp_count1_status", o_r_data, 32'h10);
    chk("pp_count1_head", o_tx_data, 8'h72);
    bus(0, BASE + 32'h14, 0, 1);

    // Unmapped accesses
    bus(1, 32'h0, 32'hCAFE_0000, 0);
    bus(1, 32'h4000_0000, 32'h1234_5678, 0); #3;
    chk("unmapped_read", o_r_data, 0);
    chk("berr_not_yet", o_bus_err, 0);
    bus(0, 32'h0, 0, 0); #3;
    chk("berr_pulse", o_bus_err, 1);
    chk("ram_no_alias", o_r_data, 32'hCAFE_0000);
    bus(0, 32'h10, 0, 0); #3;
    chk("berr_one_cycle", o_bus_err, 0);
    chk("ram_10_kept", o_r_data, 32'hDEAD_BEEF);
    bus(0, 32'h4000_0000, 0, 0);
    bus(0, BASE + 32'h14, 0, 0); #3 chk("berr_read_quiet", o_bus_err, 0);
    bus(1, BASE + 32'h18, 32'h5555_0000, 0);
    bus(0, BASE, 0, 0); #3 chk("berr_past_window", o_bus_err, 1);

    // Asynchronous reset with bytes queued and irq asserted
    bus(1, BASE + 32'hC, 0, 0);
    bus(1, BASE + 32'h8, 0, 0);
    bus(1, BASE + 32'h10, 32'h61, 0);
    bus(1, BASE + 32'h10, 32'h62, 0);
    bus(0, BASE, 0, 0); #3;
    chk("pre_rst_valid", o_tx_valid, 1);
    chk("pre_rst_irq", o_timer_irq, 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", o_tx_valid, 0);
    chk("async_rst_irq", o_timer_irq, 0);
    chk("async_rst_mtime", o_r_data, 0);
    @(posedge clk);
    #3 rstn = 1'b1;
    bus(0, BASE, 0, 0); #3 chk("post_rst_mtime", o_r_data, 1);
    bus(0, BASE + 32'h14, 0, 0); #3 chk("post_rst_status", o_r_data, 32'h02);
    bus(0, BASE, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
